decoder_3_to_8_reg: RTL and testbench



---
 rtl/led_pkg.sv | 15 +
 rtl/decoder_3_to_8_reg_if.sv | 33 +++
 rtl/decoder_3_to_8_reg_2_to_4.sv | 20 ++
 rtl/decoder_3_to_8_reg.sv | 96 +++++++++
 tb/tb_decoder_3_to_8_reg.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the 8x8 LED array driver.
//   LED_N      : number of column-select lines
//   LED_SEL_W  : width of a column index, one bit wider than needed so
//                out-of-range codes can be seen and rejected
//   col_mask_t : one-hot (or all-zero) column-select vector
//   col_sel_t  : binary column index
package led_pkg;

  localparam int LED_N     = 8;
  localparam int LED_SEL_W = $clog2(LED_N) + 1;

  typedef logic [LED_N-1:0]     col_mask_t;
  typedef logic [LED_SEL_W-1:0] col_sel_t;

endpackage : led_pkg

// File: rtl/decoder_3_to_8_reg_if.sv
// Column-select bus between the scan sequencer and the column decoder.
//   ena          : decode enable (sequencer -> decoder)
//   x            : binary column index, SEL_W bits (sequencer -> decoder)
//   out          : registered one-hot column select, N bits (decoder -> sequencer/array)
//   out_of_range : registered flag, last enabled index was >= N
// Modports: master = index source, slave = decoder.
interface decoder_3_to_8_reg_if
  import led_pkg::*;
#(
  parameter int N     = LED_N,
  parameter int SEL_W = $clog2(N) + 1
);

  logic             ena;
  logic [SEL_W-1:0] x;
  logic [N-1:0]     out;
  logic             out_of_range;

  modport master (
    output ena,
    output x,
    input  out,
    input  out_of_range
  );

  modport slave (
    input  ena,
    input  x,
    output out,
    output out_of_range
  );

endinterface : decoder_3_to_8_reg_if

// File: rtl/decoder_3_to_8_reg_2_to_4.sv
// Combinational enable-gated 2-to-4 decoder.
//   en : when low, y is all zero regardless of a
//   a  : 2-bit binary index
//   y  : one-hot decode of a when en is high
module decoder_2_to_4 (
  input  logic       en,
  input  logic [1:0] a,
  output logic [3:0] y
);

  always_comb begin
    y = 4'b0000;
    // Only index into y when enabled, so an unknown a cannot leak out
    // while the decoder is disabled.
    if (en) begin
      y[a] = 1'b1;
    end
  end

endmodule : decoder_2_to_4

// File: rtl/decoder_3_to_8_reg.sv
// Registered one-hot column decoder for the LED array driver.
// Decodes an SEL_W-bit index into N column selects with one clock of
// latency; indices >= N are flagged instead of decoded.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset, clears out and out_of_range
//   bus : column-select bus (slave side), see decoder_3_to_8_reg_if
// The interface instance must be built with the same N and SEL_W.
module decoder_3_to_8_reg
  import led_pkg::*;
#(
  parameter int N     = LED_N,
  parameter int SEL_W = $clog2(N) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  decoder_3_to_8_reg_if.slave   bus
);

  generate
    if (N < 2 || N > 8) begin : g_bad_n
      $error("decoder_3_to_8_reg: N=%0d outside 2..8", N);
    end
    if (SEL_W < $clog2(N) + 1) begin : g_bad_sel_w
      $error("decoder_3_to_8_reg: SEL_W=%0d narrower than $clog2(N)+1", SEL_W);
    end
  endgenerate

  // N expressed at full index width so the compare never drops x's top bit
  // (x=8 must not look like x=0).
  localparam logic [SEL_W-1:0] N_SEL = SEL_W'(N);

  logic       in_range;
  logic       oor_next;
  logic [2:0] idx;
  logic [7:0] dec8;
  logic [N-1:0] out_next;

  logic [N-1:0] out_reg;
  logic         oor_reg;

  // ena is evaluated first in the && so an X on x with ena low still
  // yields a clean 0 for both the decode enable and the flag.
  assign in_range = bus.ena && (bus.x < N_SEL);
  assign oor_next = bus.ena && !(bus.x < N_SEL);

  // Low three index bits feed the two 2-to-4 halves; narrow indices are
  // zero-extended.
  generate
    if (SEL_W >= 3) begin : g_idx_wide
      assign idx = bus.x[2:0];
    end else begin : g_idx_narrow
      assign idx = {{(3 - SEL_W){1'b0}}, bus.x};
    end
  endgenerate

  // x[2] picks the lower or upper half; the range check gates both.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_half
      decoder_2_to_4 u_dec (
        .en (in_range && (idx[2] == 1'(gi))),
        .a  (idx[1:0]),
        .y  (dec8[gi*4 +: 4])
      );
    end
  endgenerate

  // For N<8 the upper decode lines are never enabled (range check), and
  // slicing drops them from the output entirely.
  assign out_next = dec8[N-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg <= '0;
      oor_reg <= 1'b0;
    end else begin
      out_reg <= out_next;
      oor_reg <= oor_next;
    end
  end

  assign bus.out          = out_reg;
  assign bus.out_of_range = oor_reg;

`ifndef SYNTHESIS
  a_onehot0 : assert property (@(posedge clk) $onehot0(out_reg))
    else $error("out is not onehot0: %b", out_reg);

  a_exclusive : assert property (@(posedge clk) !(oor_reg && (|out_reg)))
    else $error("out_of_range set together with a column select");

  a_reset : assert property (@(posedge clk) rst |=> (out_reg == '0 && !oor_reg))
    else $error("outputs not cleared after reset");
`endif

endmodule : decoder_3_to_8_reg

// File: tb/tb_decoder_3_to_8_reg.sv
// Self-checking bench for decoder_3_to_8_reg: directed vector table
// followed by a seeded random run against a behavioural reference.
module tb_decoder_3_to_8_reg;
  import led_pkg::*;

  logic clk;
  logic rst;

  decoder_3_to_8_reg_if #(.N(LED_N), .SEL_W(LED_SEL_W)) bus ();

  decoder_3_to_8_reg #(.N(LED_N), .SEL_W(LED_SEL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic      rst;
    logic      ena;
    col_sel_t  x;
    col_mask_t exp_out;
    logic      exp_oor;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;

  function automatic vec_t mk(logic r, logic e, int xv, int eo, logic oo);
    vec_t v;
    v.rst     = r;
    v.ena     = e;
    v.x       = col_sel_t'(xv);
    v.exp_out = col_mask_t'(eo);
    v.exp_oor = oo;
    return v;
  endfunction

  // Behavioural expectation straight from the decode rules.
  function automatic void ref_model(input logic r, input logic e, input col_sel_t xv,
                                    output col_mask_t eo, output logic oo);
    eo = '0;
    oo = 1'b0;
    if (!r && e) begin
      if (int'(xv) < LED_N) eo[xv[2:0]] = 1'b1;
      else                  oo = 1'b1;
    end
  endfunction

  // Apply inputs, take one edge, sample 1 time unit later and compare.
  task automatic apply(input string tag, input logic r, input logic e, input col_sel_t xv,
                       input col_mask_t eo, input logic oo);
    rst     = r;
    bus.ena = e;
    bus.x   = xv;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out !== eo) begin
      errors++;
      $display("FAIL %s out: got %02h expected %02h (rst=%0b ena=%0b x=%0d)",
               tag, bus.out, eo, r, e, xv);
    end
    checks++;
    if (bus.out_of_range !== oo) begin
      errors++;
      $display("FAIL %s out_of_range: got %0b expected %0b (rst=%0b ena=%0b x=%0d)",
               tag, bus.out_of_range, oo, r, e, xv);
    end
    $display("%s rst=%0b ena=%0b x=%0d -> out=%02h oor=%0b", tag, r, e, xv,
             bus.out, bus.out_of_range);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst     = 1'b1;
    bus.ena = 1'b1;
    bus.x   = col_sel_t'(3);

    // Reset held two cycles with a live index, then released.
    vecs.push_back(mk(1, 1, 3, 8'h00, 0));
    vecs.push_back(mk(1, 1, 3, 8'h00, 0));
    vecs.push_back(mk(0, 1, 3, 8'h08, 0));
    // Full in-range sweep.
    vecs.push_back(mk(0, 1, 0, 8'h01, 0));
    vecs.push_back(mk(0, 1, 1, 8'h02, 0));
    vecs.push_back(mk(0, 1, 2, 8'h04, 0));
    vecs.push_back(mk(0, 1, 3, 8'h08, 0));
    vecs.push_back(mk(0, 1, 4, 8'h10, 0));
    vecs.push_back(mk(0, 1, 5, 8'h20, 0));
    vecs.push_back(mk(0, 1, 6, 8'h40, 0));
    vecs.push_back(mk(0, 1, 7, 8'h80, 0));
    // Out-of-range codes, including 8 which must not alias to column 0.
    vecs.push_back(mk(0, 1, 8,  8'h00, 1));
    vecs.push_back(mk(0, 1, 15, 8'h00, 1));
    vecs.push_back(mk(0, 1, 0,  8'h01, 0));
    // Enable toggling with index held.
    vecs.push_back(mk(0, 1, 5, 8'h20, 0));
    vecs.push_back(mk(0, 0, 5, 8'h00, 0));
    vecs.push_back(mk(0, 1, 5, 8'h20, 0));
    // Disabled with an out-of-range index: no flag.
    vecs.push_back(mk(0, 1, 9, 8'h00, 1));
    vecs.push_back(mk(0, 0, 9, 8'h00, 0));
    // Reset mid-operation from column 7.
    vecs.push_back(mk(0, 1, 7, 8'h80, 0));
    vecs.push_back(mk(1, 1, 7, 8'h00, 0));
    vecs.push_back(mk(1, 1, 7, 8'h00, 0));
    vecs.push_back(mk(0, 1, 7, 8'h80, 0));
    // Reset clears an out-of-range flag too.
    vecs.push_back(mk(0, 1, 12, 8'h00, 1));
    vecs.push_back(mk(1, 1, 12, 8'h00, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply($sformatf("vec%0d", i), vecs[i].rst, vecs[i].ena, vecs[i].x,
            vecs[i].exp_out, vecs[i].exp_oor);
    end

    // Random run: each cycle's result depends only on that cycle's inputs.
    void'($urandom(32'h1ED5));
    for (int i = 0; i < 1000; i++) begin
      logic      r;
      logic      e;
      col_sel_t  xv;
      col_mask_t eo;
      logic      oo;
      r  = ($urandom_range(0, 19) == 0);
      e  = ($urandom_range(0, 3) != 0);
      xv = col_sel_t'($urandom_range(0, 15));
      ref_model(r, e, xv, eo, oo);
      apply($sformatf("rnd%0d", i), r, e, xv, eo, oo);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_decoder_3_to_8_reg
